// File: rtl/relogio_pkg.sv
// rtl/relogio_pkg.sv - shared seven-segment constants and decoder for the clock display
//
// Purpose: active-low segment encodings (bit 6 = a ... bit 0 = g) used by the
// display engine.
// Contents:
//   SEG_DASH  - only segment g lit, shown for out-of-range field values
//   SEG_BLANK - all segments dark
//   seg7()    - BCD digit to active-low a..g pattern
package relogio_pkg;

    localparam logic [6:0] SEG_DASH  = 7'b111_1110;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    function automatic logic [6:0] seg7(input logic [3:0] i_digit);
        logic [6:0] w_seg;
        case (i_digit)
            4'd0:    w_seg = 7'b000_0001;
            4'd1:    w_seg = 7'b100_1111;
            4'd2:    w_seg = 7'b001_0010;
            4'd3:    w_seg = 7'b000_0110;
            4'd4:    w_seg = 7'b100_1100;
            4'd5:    w_seg = 7'b010_0100;
            4'd6:    w_seg = 7'b010_0000;
            4'd7:    w_seg = 7'b000_1111;
            4'd8:    w_seg = 7'b000_0000;
            4'd9:    w_seg = 7'b000_0100;
            default: w_seg = SEG_BLANK;
        endcase
        return w_seg;
    endfunction

endpackage

// File: rtl/relogio_blink_gen.sv
// rtl/relogio_blink_gen.sv - half-period counter producing the blink visibility phase
//
// Purpose: counts HALF_CYCLES clocks per phase and toggles o_visible at each
// terminal count. i_restart synchronously clears the counter and forces the
// visible phase, so a freshly selected field appears at once.
// Ports:
//   i_clk      - clock
//   i_rst_n    - asynchronous active-low reset (phase visible, counter 0)
//   i_restart  - synchronous restart
//   o_visible  - 1 = visible phase, 0 = blanked phase
module relogio_blink_gen #(
    parameter int unsigned HALF_CYCLES = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_visible
);

    localparam int unsigned CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_visible;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_visible <= 1'b1;
        end else if (i_restart) begin
            r_cnt     <= '0;
            r_visible <= 1'b1;
        end else if (r_cnt == CW'(HALF_CYCLES - 1)) begin
            r_cnt     <= '0;
            r_visible <= ~r_visible;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_visible = r_visible;

endmodule

// File: rtl/relogio_display_campos.sv
// rtl/relogio_display_campos.sv - multiplexed 7-seg scan engine for 2-digit clock fields
//
// Purpose: snapshots NUM_FIELDS binary fields once per frame, converts each to
// two BCD digits and scans them onto a DIGITS-wide active-low display, blinking
// the field selected for adjustment.
// Ports:
//   clk_100MHz - system clock
//   reset      - asynchronous active-low reset
//   campos     - field k at [k*FIELD_W +: FIELD_W], field 0 rightmost
//   sel_ajuste - 0 = none, k = field k-1 blinks, > NUM_FIELDS = none
//   pontos     - decimal point request per digit, 1 = lit
//   an         - anodes, active-low
//   dec_ddp    - [7:1] segments a..g, [0] dp, active-low
module relogio_display_campos
    import relogio_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned SCAN_HZ    = 1000,
    parameter int unsigned BLINK_MS   = 500,
    parameter int unsigned NUM_FIELDS = 3,
    parameter int unsigned FIELD_W    = 7,
    parameter int unsigned DIGITS     = 8
) (
    input  logic                            clk_100MHz,
    input  logic                            reset,
    input  logic [NUM_FIELDS*FIELD_W-1:0]   campos,
    input  logic [$clog2(NUM_FIELDS+1)-1:0] sel_ajuste,
    input  logic [DIGITS-1:0]               pontos,
    output logic [DIGITS-1:0]               an,
    output logic [7:0]                      dec_ddp
);

    localparam int unsigned SCAN_DIV    = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int unsigned HALF_CYCLES = BLINK_MS * (CLK_HZ / 1000);
    localparam int unsigned SCW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDXW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SELW        = $clog2(NUM_FIELDS + 1);

    if (NUM_FIELDS < 1 || NUM_FIELDS * 2 > DIGITS) begin : g_chk_fields
        $error("NUM_FIELDS must lie in 1..DIGITS/2");
    end
    if (SCAN_DIV < 1) begin : g_chk_scan
        $error("CLK_HZ/(SCAN_HZ*DIGITS) must be at least 1");
    end

    logic [SCW-1:0]                r_scan_cnt;
    logic [IDXW-1:0]               r_idx;
    logic [NUM_FIELDS*FIELD_W-1:0] r_campos;
    logic [DIGITS-1:0]             r_pontos;
    logic [SELW-1:0]               r_sel_prev;

    logic              w_tick;
    logic              w_idx_last;
    logic              w_sel_chg;
    logic              w_blink_vis;
    logic              w_visible;
    logic [DIGITS-1:0] w_an_next;
    logic [7:0]        w_dec_next;
    logic [31:0]       w_val;
    logic [31:0]       w_k;
    logic [3:0]        w_bcd;
    logic [6:0]        w_seg;
    logic              w_blank_blink;

    assign w_tick     = (r_scan_cnt == SCW'(SCAN_DIV - 1));
    assign w_idx_last = (r_idx == IDXW'(DIGITS - 1));
    assign w_sel_chg  = (sel_ajuste != r_sel_prev);
    // A selection change wins over the stored phase on the very edge it is
    // detected, so a tick landing on that edge already shows the field.
    assign w_visible  = w_blink_vis | w_sel_chg;

    relogio_blink_gen #(
        .HALF_CYCLES (HALF_CYCLES)
    ) u_blink (
        .i_clk     (clk_100MHz),
        .i_rst_n   (reset),
        .i_restart (w_sel_chg),
        .o_visible (w_blink_vis)
    );

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_campos   <= '0;
            r_pontos   <= '0;
            r_sel_prev <= '0;
            an         <= '1;
            dec_ddp    <= '1;
        end else begin
            r_sel_prev <= sel_ajuste;
            if (w_tick) begin
                r_scan_cnt <= '0;
                r_idx      <= w_idx_last ? '0 : r_idx + 1'b1;
                an         <= w_an_next;
                dec_ddp    <= w_dec_next;
                // Capture on the wrap so the next frame reads one coherent set.
                if (w_idx_last) begin
                    r_campos <= campos;
                    r_pontos <= pontos;
                end
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_an_next     = '1;
        w_dec_next    = '1;
        w_k           = 32'(r_idx) >> 1;
        w_val         = '0;
        w_bcd         = '0;
        w_seg         = SEG_BLANK;
        w_blank_blink = 1'b0;
        if (32'(r_idx) < 2 * NUM_FIELDS) begin
            w_val = 32'(FIELD_W'(r_campos >> (w_k * FIELD_W)));
            if (w_val >= 100) begin
                w_seg = SEG_DASH;
            end else begin
                w_bcd = r_idx[0] ? 4'(w_val / 10) : 4'(w_val % 10);
                w_seg = seg7(w_bcd);
            end
            w_blank_blink = (32'(sel_ajuste) == w_k + 1) && !w_visible;
            w_dec_next    = {w_seg, w_blank_blink ? 1'b1 : ~r_pontos[r_idx]};
            if (!w_blank_blink) begin
                w_an_next[r_idx] = 1'b0;
            end
        end
    end

endmodule
